// File: rtl/pipe_reg_stage.sv
// pipe_reg_stage: valid/ready pipeline register with 2-entry skid buffer, flush and saturating stall counter
module pipe_reg_stage #(
   parameter int DATA_WIDTH = 64,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  flush,
   input  logic                  in_valid,
   input  logic [DATA_WIDTH-1:0] in_data,
   output logic                  in_ready,
   output logic                  out_valid,
   output logic [DATA_WIDTH-1:0] out_data,
   input  logic                  out_ready,
   output logic [1:0]            occupancy,
   output logic [CNT_WIDTH-1:0]  stall_cnt
);
   localparam logic [1:0] S_EMPTY = 2'd0;
   localparam logic [1:0] S_ONE   = 2'd1;
   localparam logic [1:0] S_FULL  = 2'd2;
   logic [1:0]            r_state;
   logic [DATA_WIDTH-1:0] r_main;
   logic [DATA_WIDTH-1:0] r_skid;
   logic [CNT_WIDTH-1:0]  r_cnt;
   logic                  w_accept;
   logic                  w_drain;
   logic                  w_stall;
   // state encoding equals occupancy, so outputs are plain decodes of registers
   assign occupancy = r_state;
   assign out_valid = r_state != S_EMPTY;
   assign in_ready  = r_state != S_FULL;
   assign out_data  = r_main;
   assign stall_cnt = r_cnt;
   assign w_accept  = in_valid & in_ready;
   assign w_drain   = out_valid & out_ready;
   assign w_stall   = out_valid & ~out_ready;
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state <= S_EMPTY;
         r_main  <= '0;
         r_skid  <= '0;
         r_cnt   <= '0;
      end else begin
         if (w_stall && r_cnt != {CNT_WIDTH{1'b1}}) r_cnt <= r_cnt + 1'b1;
         if (flush) begin
            r_state <= S_EMPTY;
            r_main  <= '0;
            r_skid  <= '0;
         end else if (w_accept && (r_state == S_EMPTY || w_drain)) begin
            r_state <= S_ONE;
            r_main  <= in_data;
         end else if (w_accept) begin
            r_state <= S_FULL;
            r_skid  <= in_data;
         end else if (w_drain) begin
            // FULL promotes skid to main; ONE empties to an all-zero bubble
            r_state <= r_state - 2'd1;
            r_main  <= (r_state == S_FULL) ? r_skid : '0;
            r_skid  <= '0;
         end
      end
   end
endmodule

// File: tb/tb_pipe_reg_stage.sv
// tb_pipe_reg_stage: directed vectors for pipe_reg_stage with hand-computed expectations
module tb_pipe_reg_stage;
   localparam int DW = 16;
   localparam int CW = 4;
   logic          clk = 1'b0;
   logic          rst, flush, in_valid, in_ready, out_valid, out_ready;
   logic [DW-1:0] in_data, out_data;
   logic [1:0]    occupancy;
   logic [CW-1:0] stall_cnt;
   int            n_vec = 0;
   int            n_bad = 0;
   int            exp_cnt;

   pipe_reg_stage #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
      .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
      .occupancy(occupancy), .stall_cnt(stall_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_all(input string tag, input logic v, input logic [DW-1:0] d,
                          input logic r, input logic [1:0] o, input int c);
      chk({tag, ".out_valid"}, 32'(out_valid), 32'(v));
      chk({tag, ".out_data"},  32'(out_data),  32'(d));
      chk({tag, ".in_ready"},  32'(in_ready),  32'(r));
      chk({tag, ".occupancy"}, 32'(occupancy), 32'(o));
      chk({tag, ".stall_cnt"}, 32'(stall_cnt), 32'(c));
   endtask

   initial begin
      rst = 1'b0; flush = 1'b0; in_valid = 1'b1; in_data = 16'hDEAD; out_ready = 1'b0;
      for (int i = 0; i < 2; i++) begin
         tick();
         chk_all("reset_hold", 0, 0, 1, 0, 0);
      end
      rst = 1'b1; in_valid = 1'b0;
      tick();
      chk_all("reset_release", 0, 0, 1, 0, 0);

      out_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         in_valid = 1'b1; in_data = DW'(16'h11 + i);
         tick();
         chk_all("stream", 1, DW'(16'h11 + i), 1, 1, 0);
      end
      in_valid = 1'b0;
      tick();
      chk_all("stream_drained", 0, 0, 1, 0, 0);

      out_ready = 1'b0; in_valid = 1'b1; in_data = 16'hA;
      tick();
      chk_all("bp_a", 1, 16'hA, 1, 1, 0);
      in_data = 16'hB;
      tick();
      chk_all("bp_b", 1, 16'hA, 0, 2, 1);
      in_data = 16'hC;
      tick();
      chk_all("bp_hold1", 1, 16'hA, 0, 2, 2);
      tick();
      chk_all("bp_hold2", 1, 16'hA, 0, 2, 3);
      out_ready = 1'b1;
      tick();
      chk_all("bp_out_b", 1, 16'hB, 1, 1, 3);
      tick();
      chk_all("bp_out_c", 1, 16'hC, 1, 1, 3);
      in_valid = 1'b0;
      tick();
      chk_all("bp_empty", 0, 0, 1, 0, 3);

      out_ready = 1'b0; in_valid = 1'b1; in_data = 16'h1;
      tick();
      chk_all("fl_fill1", 1, 16'h1, 1, 1, 3);
      in_data = 16'h2;
      tick();
      chk_all("fl_fill2", 1, 16'h1, 0, 2, 4);
      flush = 1'b1; in_data = 16'h3;
      tick();
      chk_all("fl_bubble", 0, 0, 1, 0, 5);
      flush = 1'b0; in_valid = 1'b0;
      tick();
      chk_all("fl_after", 0, 0, 1, 0, 5);

      in_valid = 1'b1; in_data = 16'h55;
      tick();
      chk_all("sat_load", 1, 16'h55, 1, 1, 5);
      in_valid = 1'b0;
      exp_cnt = 5;
      for (int i = 0; i < 20; i++) begin
         tick();
         exp_cnt = (exp_cnt < 15) ? exp_cnt + 1 : 15;
         chk("sat_cnt", 32'(stall_cnt), 32'(exp_cnt));
      end
      chk_all("sat_end", 1, 16'h55, 1, 1, 15);

      rst = 1'b0;
      tick();
      rst = 1'b1; in_valid = 1'b1; in_data = 16'h66;
      tick();
      chk_all("mr_one", 1, 16'h66, 1, 1, 0);
      in_data = 16'h77;
      tick();
      chk_all("mr_full", 1, 16'h66, 0, 2, 1);
      in_valid = 1'b0;
      repeat (6) tick();
      chk_all("mr_cnt7", 1, 16'h66, 0, 2, 7);
      rst = 1'b0; in_valid = 1'b1; in_data = 16'h99; out_ready = 1'b1;
      tick();
      chk_all("mr_reset", 0, 0, 1, 0, 0);
      rst = 1'b1; in_valid = 1'b0;
      tick();
      chk_all("mr_discard", 0, 0, 1, 0, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
